// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

  localparam int REG_X0         = 0;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int MC_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall/flush statistics.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, branch flushes and multi-cycle EX waits.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic                  rs1_used_D,
  input  logic                  rs2_used_D,
  input  logic [REG_ADDR_W-1:0] rd_E,
  input  logic                  mem_read_E,
  input  logic                  pc_src_E,
  input  logic                  mc_start_E,
  input  logic                  mc_done,
  input  logic                  clear_counters,
  output logic                  pc_write_zero,
  output logic                  if_id_hold,
  output logic                  IF_pipeline_write_zero,
  output logic                  id_ex_flush,
  output logic                  id_ex_hold,
  output logic                  ex_mem_bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  mc_timeout
);

  localparam int CYC_W = $clog2(MC_TIMEOUT + 1);

  hz_state_t        state, state_nxt;
  logic [CYC_W-1:0] mc_cyc, mc_cyc_nxt;
  logic             timeout_set;
  logic             luh;
  logic             pcw_c, ifh_c, ifz_c, idf_c, idh_c, exb_c;

  assign luh = mem_read_E && (rd_E != REG_ADDR_W'(REG_X0)) &&
               ((rs1_used_D && (rs1_D == rd_E)) || (rs2_used_D && (rs2_D == rd_E)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      mc_cyc     <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      mc_cyc <= mc_cyc_nxt;
      if (timeout_set) mc_timeout <= 1'b1;
    end
  end

  // Priority: branch flush > multi-cycle wait > multi-cycle start > load-use.
  always_comb begin
    state_nxt   = state;
    mc_cyc_nxt  = mc_cyc;
    timeout_set = 1'b0;
    pcw_c       = 1'b0;
    ifh_c       = 1'b0;
    ifz_c       = 1'b0;
    idf_c       = 1'b0;
    idh_c       = 1'b0;
    exb_c       = 1'b0;
    if (pc_src_E) begin
      ifz_c      = 1'b1;
      idf_c      = 1'b1;
      state_nxt  = RUN;
      mc_cyc_nxt = '0;
    end else if (state == MC_WAIT) begin
      if (!mc_done) begin
        pcw_c      = 1'b1;
        ifh_c      = 1'b1;
        idh_c      = 1'b1;
        exb_c      = 1'b1;
        mc_cyc_nxt = mc_cyc + 1'b1;
        if (mc_cyc == CYC_W'(MC_TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_nxt   = RUN;
          mc_cyc_nxt  = '0;
        end
      end else begin
        state_nxt  = RUN;
        mc_cyc_nxt = '0;
      end
    end else if (mc_start_E) begin
      if (!mc_done) begin
        pcw_c      = 1'b1;
        ifh_c      = 1'b1;
        idh_c      = 1'b1;
        exb_c      = 1'b1;
        state_nxt  = MC_WAIT;
        mc_cyc_nxt = CYC_W'(1);
      end
    end else if (luh) begin
      pcw_c = 1'b1;
      ifh_c = 1'b1;
      idf_c = 1'b1;
    end
  end

  assign pc_write_zero          = reset & pcw_c;
  assign if_id_hold             = reset & ifh_c;
  assign IF_pipeline_write_zero = reset & ifz_c;
  assign id_ex_flush            = reset & idf_c;
  assign id_ex_hold             = reset & idh_c;
  assign ex_mem_bubble          = reset & exb_c;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_write_zero),
    .clr   (clear_counters),
    .q     (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (IF_pipeline_write_zero),
    .clr   (clear_counters),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random checking of pipeline_hazard_ctrl against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int RW    = 5;
  localparam int MC_TO = 8;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] rs1_D, rs2_D, rd_E;
  logic          rs1_used_D, rs2_used_D, mem_read_E, pc_src_E;
  logic          mc_start_E, mc_done, clear_counters;
  logic          pc_write_zero, if_id_hold, IF_pipeline_write_zero;
  logic          id_ex_flush, id_ex_hold, ex_mem_bubble, mc_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: whether a multi-cycle op is outstanding, how many cycles it has stalled.
  bit m_wait = 0;
  int m_len = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_to = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MC_TIMEOUT(MC_TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D), .rd_E(rd_E),
    .mem_read_E(mem_read_E), .pc_src_E(pc_src_E), .mc_start_E(mc_start_E),
    .mc_done(mc_done), .clear_counters(clear_counters),
    .pc_write_zero(pc_write_zero), .if_id_hold(if_id_hold),
    .IF_pipeline_write_zero(IF_pipeline_write_zero), .id_ex_flush(id_ex_flush),
    .id_ex_hold(id_ex_hold), .ex_mem_bubble(ex_mem_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mc_timeout(mc_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_D = '0; rs2_D = '0; rd_E = '0;
    rs1_used_D = 0; rs2_used_D = 0; mem_read_E = 0;
    pc_src_E = 0; mc_start_E = 0; mc_done = 0; clear_counters = 0;
  endtask

  // kind: 0 nothing, 1 branch flush, 2 multi-cycle stall, 3 load-use bubble
  task automatic step();
    int  kind;
    bit  luh;
    #2;
    luh = mem_read_E && (rd_E != 0) &&
          ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E));
    if (!reset)                    kind = 0;
    else if (pc_src_E)             kind = 1;
    else if (m_wait)               kind = mc_done ? 0 : 2;
    else if (mc_start_E)           kind = mc_done ? 0 : 2;
    else if (luh)                  kind = 3;
    else                           kind = 0;
    chk("pc_write_zero", 32'(pc_write_zero), 32'(kind == 2 || kind == 3));
    chk("if_id_hold",    32'(if_id_hold),    32'(kind == 2 || kind == 3));
    chk("if_id_zero",    32'(IF_pipeline_write_zero), 32'(kind == 1));
    chk("id_ex_flush",   32'(id_ex_flush),   32'(kind == 1 || kind == 3));
    chk("id_ex_hold",    32'(id_ex_hold),    32'(kind == 2));
    chk("ex_mem_bubble", 32'(ex_mem_bubble), 32'(kind == 2));
    @(posedge clk);
    if (!reset) begin
      m_wait = 0; m_len = 0; m_stall = 0; m_flush = 0; m_to = 0;
    end else begin
      if (clear_counters) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if ((kind == 2 || kind == 3) && m_stall < MAXC) m_stall++;
        if (kind == 1 && m_flush < MAXC) m_flush++;
      end
      if (pc_src_E) m_wait = 0;
      else if (m_wait) begin
        if (!mc_done) begin
          m_len++;
          if (m_len == MC_TO) begin m_to = 1; m_wait = 0; end
        end else m_wait = 0;
      end else if (mc_start_E && !mc_done) begin
        m_wait = 1; m_len = 1;
      end
    end
    #1;
    chk("stall_cnt",  32'(stall_cnt),  32'(m_stall));
    chk("flush_cnt",  32'(flush_cnt),  32'(m_flush));
    chk("mc_timeout", 32'(mc_timeout), 32'(m_to));
  endtask

  initial begin
    idle();
    reset = 0;
    @(posedge clk); #1;

    // Reset held with a branch pending: outputs must stay quiet.
    pc_src_E = 1;
    repeat (3) begin
      step();
      chk("rst_ifz_forced", 32'(IF_pipeline_write_zero), 32'd0);
    end
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    reset = 1; idle();
    step();

    // Load-use on rs2, then the same with x0 as destination.
    mem_read_E = 1; rd_E = 5; rs2_D = 5; rs2_used_D = 1;
    step();
    chk("luh_stall_cnt", 32'(stall_cnt), 32'd1);
    idle(); step();
    chk("luh_released", 32'(pc_write_zero), 32'd0);
    mem_read_E = 1; rd_E = 0; rs2_D = 0; rs2_used_D = 1;
    step();
    chk("luh_x0_cnt", 32'(stall_cnt), 32'd1);

    // Branch overriding a load-use hazard.
    mem_read_E = 1; rd_E = 7; rs1_D = 7; rs1_used_D = 1; pc_src_E = 1;
    step();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Multi-cycle op finishing on the fourth cycle after start.
    idle(); clear_counters = 1; step(); idle();
    mc_start_E = 1; step(); mc_start_E = 0;
    repeat (3) step();
    mc_done = 1; step();
    chk("mc_released", 32'(pc_write_zero), 32'd0);
    chk("mc_stall_cnt", 32'(stall_cnt), 32'd4);
    mc_done = 0;
    mc_start_E = 1; mc_done = 1; step();
    chk("mc_single_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: no completion ever arrives.
    idle(); clear_counters = 1; step(); idle();
    mc_start_E = 1; step(); mc_start_E = 0;
    repeat (10) step();
    chk("to_stall_cnt", 32'(stall_cnt), 32'd8);
    chk("to_flag", 32'(mc_timeout), 32'd1);
    mc_start_E = 1; step(); mc_start_E = 0;
    chk("to_restart_stall", 32'(stall_cnt), 32'd9);
    mc_done = 1; step(); mc_done = 0;
    chk("to_sticky", 32'(mc_timeout), 32'd1);

    // Branch while waiting on a multi-cycle op.
    mc_start_E = 1; step(); mc_start_E = 0;
    step();
    pc_src_E = 1; step();
    chk("br_mc_ifz", 32'(IF_pipeline_write_zero), 32'd1);
    idle(); step();
    chk("br_mc_release", 32'(pc_write_zero), 32'd0);

    // Saturation and clear.
    mem_read_E = 1; rd_E = 3; rs1_D = 3; rs1_used_D = 1;
    repeat (MAXC + 5) step();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'(MAXC));
    clear_counters = 1; step();
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    idle(); step();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(99) != 0);
      rs1_D          = RW'($urandom_range(3));
      rs2_D          = RW'($urandom_range(3));
      rd_E           = RW'($urandom_range(3));
      rs1_used_D     = $urandom_range(1);
      rs2_used_D     = $urandom_range(1);
      mem_read_E     = $urandom_range(1);
      pc_src_E       = ($urandom_range(9) == 0);
      mc_start_E     = ($urandom_range(5) == 0);
      mc_done        = ($urandom_range(11) == 0);
      clear_counters = ($urandom_range(39) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
